// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte sources. Every source
//   owns a one-byte holding register. A round-robin scheduler picks one
//   pending byte at a time and issues it to the transmitter as a one-cycle
//   send_en pulse with send_data. The next grant waits until the transmitter
//   has taken the byte (tx_busy rose and fell again) or the wait for tx_busy
//   has timed out.
//
// Ports
//   sys_clk       system clock
//   sys_rst_n     asynchronous reset, active low
//   req_valid     per source: one-cycle strobe offering a byte
//   req_data      per source: packed bytes, source i at [8i+7:8i]
//   req_full      per source: holding register occupied
//   req_overflow  per source: sticky, a byte from that source was dropped
//   clr_overflow  one-cycle strobe clearing every req_overflow bit
//   tx_busy       transmitter busy level
//   send_en       one-cycle start pulse to the transmitter
//   send_data     byte being transmitted, valid during send_en
//   grant_id      index of the most recently granted source
//   tx_timeout    one-cycle pulse: tx_busy never rose for the issued byte

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_full,
    output logic [NUM_REQ-1:0]     req_overflow,
    input  logic                   clr_overflow,
    input  logic                   tx_busy,
    output logic                   send_en,
    output logic [7:0]             send_data,
    output logic [1:0]             grant_id,
    output logic                   tx_timeout
);

    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [1:0]       PTR_INIT = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         hold_q [NUM_REQ];
    logic [7:0]         hold_d [NUM_REQ];
    logic [NUM_REQ-1:0] full_q, full_d;
    logic [NUM_REQ-1:0] ovf_q, ovf_d;
    logic               send_en_q, send_en_d;
    logic [7:0]         send_data_q, send_data_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               tx_timeout_q, tx_timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               grant_found;
    logic [1:0]         grant_sel;
    logic [NUM_REQ-1:0] grant_oh;
    logic [7:0]         grant_byte;
    logic               grant_en;

    // Round-robin search: first scan the sources above the pointer, then
    // wrap around to the ones at or below it.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        grant_oh    = '0;
        grant_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && full_q[i] && (i > int'(rr_ptr_q))) begin
                grant_found = 1'b1;
                grant_sel   = 2'(i);
                grant_oh[i] = 1'b1;
                grant_byte  = hold_q[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && full_q[i] && (i <= int'(rr_ptr_q))) begin
                grant_found = 1'b1;
                grant_sel   = 2'(i);
                grant_oh[i] = 1'b1;
                grant_byte  = hold_q[i];
            end
        end
    end

    assign grant_en = (state_q == IDLE) && grant_found && !tx_busy;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        full_d       = full_q;
        send_en_d    = 1'b0;
        send_data_d  = send_data_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        tx_timeout_d = 1'b0;
        cnt_d        = cnt_q;
        // Clearing first lets an overflow in the same cycle win.
        ovf_d        = clr_overflow ? '0 : ovf_q;

        if (grant_en) begin
            full_d = full_q & ~grant_oh;
        end

        // A register being granted this cycle is free to take a new byte.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (!full_q[i] || (grant_en && grant_oh[i])) begin
                    hold_d[i] = req_data[8*i +: 8];
                    full_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    send_en_d   = 1'b1;
                    send_data_d = grant_byte;
                    grant_id_d  = grant_sel;
                    rr_ptr_d    = grant_sel;
                    cnt_d       = '0;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // The byte is abandoned; it is not re-queued.
                    tx_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '{default: 8'h00};
            full_q       <= '0;
            ovf_q        <= '0;
            send_en_q    <= 1'b0;
            send_data_q  <= 8'h00;
            grant_id_q   <= 2'd0;
            rr_ptr_q     <= PTR_INIT;
            tx_timeout_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            send_en_q    <= send_en_d;
            send_data_q  <= send_data_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            tx_timeout_q <= tx_timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_full     = full_q;
    assign req_overflow = ovf_q;
    assign send_en      = send_en_q;
    assign send_data    = send_data_q;
    assign grant_id     = grant_id_q;
    assign tx_timeout   = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. Expected bytes are queued when they
//   are offered and are popped by a monitor whenever send_en is seen. A small
//   transmitter model raises tx_busy after each send_en when enabled.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int BUSY_TIMEOUT = 16;
    localparam int BUSY_LEN     = 10;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_full;
    logic [NUM_REQ-1:0]   req_overflow;
    logic                 clr_overflow;
    logic                 tx_busy;
    logic                 send_en;
    logic [7:0]           send_data;
    logic [1:0]           grant_id;
    logic                 tx_timeout;

    int   checks        = 0;
    int   failures      = 0;
    int   sent_count    = 0;
    int   timeout_count = 0;
    int   busy_cnt      = 0;
    bit   model_en      = 1'b0;
    bit   prev_send_en  = 1'b0;
    exp_t exp_q [$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_full     (req_full),
        .req_overflow (req_overflow),
        .clr_overflow (clr_overflow),
        .tx_busy      (tx_busy),
        .send_en      (send_en),
        .send_data    (send_data),
        .grant_id     (grant_id),
        .tx_timeout   (tx_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every send_en must match the oldest queued byte.
    always @(negedge sys_clk) begin
        exp_t e;
        if (send_en === 1'b1) begin
            check_output("send_en_single_cycle", 32'(prev_send_en), 32'd0);
            check_output("send_expected", 32'(exp_q.size() != 0), 32'd1);
            sent_count++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("send_data", 32'(send_data), 32'(e.data));
                check_output("grant_id", 32'(grant_id), 32'(e.id));
            end
        end
        prev_send_en = (send_en === 1'b1);
        if (tx_timeout === 1'b1) begin
            timeout_count++;
        end
    end

    // Transmitter model: busy from the send_en cycle for BUSY_LEN cycles.
    always @(negedge sys_clk) begin
        if (model_en) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy = 1'b0;
                end
            end else if (send_en === 1'b1) begin
                tx_busy  = 1'b1;
                busy_cnt = BUSY_LEN;
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] data);
        req_valid[idx]        = 1'b1;
        req_data[8*idx +: 8]  = data;
        tick();
        req_valid             = '0;
    endtask

    task automatic check_reset_values();
        check_output("rst_req_full", 32'(req_full), 32'd0);
        check_output("rst_req_overflow", 32'(req_overflow), 32'd0);
        check_output("rst_send_en", 32'(send_en), 32'd0);
        check_output("rst_send_data", 32'(send_data), 32'd0);
        check_output("rst_grant_id", 32'(grant_id), 32'd0);
        check_output("rst_tx_timeout", 32'(tx_timeout), 32'd0);
    endtask

    task automatic apply_reset();
        sys_rst_n    = 1'b0;
        model_en     = 1'b0;
        tx_busy      = 1'b0;
        busy_cnt     = 0;
        req_valid    = '0;
        clr_overflow = 1'b0;
        #1;
        check_reset_values();
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_sent(input int target);
        for (int i = 0; i < 200; i++) begin
            if (sent_count >= target) break;
            tick();
        end
        check_output("wait_sent_bound", 32'(sent_count >= target), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && tx_busy == 1'b0 && req_full == '0) break;
            tick();
        end
        check_output("drain_bound", 32'(exp_q.size() == 0 && tx_busy == 1'b0 && req_full == '0), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        sys_rst_n    = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        clr_overflow = 1'b0;
        tx_busy      = 1'b0;
        #2;
        apply_reset();

        // T1: single byte, no transmitter response -> send then timeout
        $display("[TB] T1 single byte and timeout");
        exp_q.push_back('{data: 8'hA5, id: 2'd0});
        apply_stimulus(0, 8'hA5);
        check_output("t1_full_after_capture", 32'(req_full), 32'b01);
        tick();
        check_output("t1_send_en", 32'(send_en), 32'd1);
        check_output("t1_send_data", 32'(send_data), 32'hA5);
        check_output("t1_full_cleared", 32'(req_full), 32'd0);
        for (int i = 1; i < BUSY_TIMEOUT; i++) begin
            tick();
            check_output("t1_no_early_timeout", 32'(tx_timeout), 32'd0);
        end
        tick();
        check_output("t1_timeout_pulse", 32'(tx_timeout), 32'd1);
        tick();
        check_output("t1_timeout_single", 32'(tx_timeout), 32'd0);
        check_output("t1_timeout_count", 32'(timeout_count), 32'd1);
        repeat (3) tick();

        // T2: round robin with refill of source 0 while busy
        $display("[TB] T2 round robin");
        apply_reset();
        model_en = 1'b1;
        exp_q.push_back('{data: 8'h11, id: 2'd0});
        exp_q.push_back('{data: 8'h22, id: 2'd1});
        req_valid = 2'b11;
        req_data  = {8'h22, 8'h11};
        tick();
        req_valid = '0;
        check_output("t2_both_full", 32'(req_full), 32'b11);
        wait_sent(sent_count + 1);
        tick();
        exp_q.push_back('{data: 8'h55, id: 2'd0});
        apply_stimulus(0, 8'h55);
        wait_drain();
        check_output("t2_no_overflow", 32'(req_overflow), 32'd0);

        // T3: overflow on source 1 while a transfer is active
        $display("[TB] T3 overflow");
        exp_q.push_back('{data: 8'h77, id: 2'd0});
        apply_stimulus(0, 8'h77);
        wait_sent(sent_count + 1);
        exp_q.push_back('{data: 8'h01, id: 2'd1});
        apply_stimulus(1, 8'h01);
        apply_stimulus(1, 8'h02);
        check_output("t3_overflow_set", 32'(req_overflow), 32'b10);
        check_output("t3_full", 32'(req_full), 32'b10);
        wait_drain();
        check_output("t3_overflow_sticky", 32'(req_overflow), 32'b10);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_output("t3_overflow_cleared", 32'(req_overflow), 32'd0);

        // T4: refill of hold 0 on its own grant edge
        $display("[TB] T4 same-cycle refill");
        exp_q.push_back('{data: 8'h44, id: 2'd0});
        exp_q.push_back('{data: 8'h33, id: 2'd0});
        apply_stimulus(0, 8'h44);
        apply_stimulus(0, 8'h33);
        check_output("t4_send_en", 32'(send_en), 32'd1);
        check_output("t4_send_data", 32'(send_data), 32'h44);
        check_output("t4_still_full", 32'(req_full), 32'b01);
        check_output("t4_no_overflow", 32'(req_overflow), 32'd0);
        wait_drain();
        check_output("t4_no_overflow_end", 32'(req_overflow), 32'd0);

        // T5: tx_busy already high while a byte is pending
        $display("[TB] T5 busy gating");
        model_en = 1'b0;
        tx_busy  = 1'b1;
        exp_q.push_back('{data: 8'h66, id: 2'd1});
        apply_stimulus(1, 8'h66);
        for (int i = 0; i < 5; i++) begin
            check_output("t5_no_send_while_busy", 32'(send_en), 32'd0);
            tick();
        end
        check_output("t5_pending", 32'(req_full), 32'b10);
        model_en = 1'b1;
        tx_busy  = 1'b0;
        tick();
        check_output("t5_send_en", 32'(send_en), 32'd1);
        check_output("t5_send_data", 32'(send_data), 32'h66);
        tick();
        check_output("t5_single_pulse", 32'(send_en), 32'd0);
        wait_drain();

        // T6: reset during WAIT_DONE with both holds pending
        $display("[TB] T6 reset mid-transfer");
        exp_q.push_back('{data: 8'h88, id: 2'd0});
        apply_stimulus(0, 8'h88);
        wait_sent(sent_count + 1);
        req_valid = 2'b11;
        req_data  = {8'hAA, 8'h99};
        tick();
        req_valid = '0;
        check_output("t6_both_pending", 32'(req_full), 32'b11);
        apply_reset();
        begin
            int sent_before;
            sent_before = sent_count;
            repeat (20) tick();
            check_output("t6_no_send_after_reset", 32'(sent_count), 32'(sent_before));
        end
        check_output("t6_full_discarded", 32'(req_full), 32'd0);

        check_output("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check_output("end_timeout_count", 32'(timeout_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
